usr_burst: RTL and testbench



---
 rtl/usr_pkg.sv | 26 ++
 rtl/usr_step.sv | 31 +++
 rtl/usr_burst.sv | 98 +++++++++
 tb/tb_usr_burst.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHR  = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_LOAD = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_ROL  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

  // Only the single-position movement modes make sense repeated as a burst.
  function automatic logic is_burst_mode(input usr_mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next-value function of the shift register, shared by the
// single-step and burst paths.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  usr_mode_e        mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (mode)
      MODE_HOLD: nxt = cur;
      MODE_SHR:  nxt = {msb_in, cur[WIDTH-1:1]};
      MODE_SHL:  nxt = {cur[WIDTH-2:0], lsb_in};
      MODE_LOAD: nxt = data_in;
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_CLR:  nxt = '0;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/usr_burst.sv
// Parametrised universal shift register with an autonomous burst engine that
// repeats a single-position shift/rotate a programmed number of times.
module usr_burst
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CW-1:0]    shamt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] data_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  usr_state_e       state, state_n;
  usr_mode_e        bmode, bmode_n;
  usr_mode_e        mode_in, step_mode;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_r, data_n, step_out;
  logic             done_n;

  assign mode_in = usr_mode_e'(mode);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .mode    (step_mode),
    .cur     (data_r),
    .msb_in  (msb_in),
    .lsb_in  (lsb_in),
    .data_in (data_in),
    .nxt     (step_out)
  );

  always_comb begin
    state_n   = state;
    bmode_n   = bmode;
    cnt_n     = cnt;
    done_n    = 1'b0;
    step_mode = mode_in;
    data_n    = step_out;
    unique case (state)
      IDLE: begin
        // A burst request holds the register on the accepting edge; shifting starts next edge.
        if (start && is_burst_mode(mode_in)) begin
          data_n = data_r;
          if (shamt != '0) begin
            bmode_n = mode_in;
            cnt_n   = shamt;
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        step_mode = bmode;
        data_n    = step_out;
        cnt_n     = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bmode  <= MODE_HOLD;
      cnt    <= '0;
      data_r <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      bmode  <= bmode_n;
      cnt    <= cnt_n;
      data_r <= data_n;
      busy   <= (state_n == RUN);
      done   <= done_n;
    end
  end

  assign data_out = data_r;
  assign msb_out  = data_r[WIDTH-1];
  assign lsb_out  = data_r[0];

endmodule

// File: tb/tb_usr_burst.sv
// Scoreboard bench for usr_burst (WIDTH=8): directed vectors push expected
// register/status values, a negedge monitor pops and compares them.
module tb_usr_burst;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       mode;
  logic             start;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] data_in;
  logic             msb_in, lsb_in;
  logic [WIDTH-1:0] data_out;
  logic             msb_out, lsb_out, busy, done;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vec_id = 0;

  always #5 clk = ~clk;

  usr_burst #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .start    (start),
    .shamt    (shamt),
    .data_in  (data_in),
    .msb_in   (msb_in),
    .lsb_in   (lsb_in),
    .data_out (data_out),
    .msb_out  (msb_out),
    .lsb_out  (lsb_out),
    .busy     (busy),
    .done     (done)
  );

  // Drive one cycle of inputs, then record what the register must hold after that edge.
  task automatic vec(input logic r, input logic [2:0] m, input logic s,
                     input logic [CW-1:0] sh, input logic [7:0] d,
                     input logic mi, input logic li,
                     input logic [7:0] ed, input logic eb, input logic edn);
    exp_t e;
    rst = r; mode = m; start = s; shamt = sh; data_in = d; msb_in = mi; lsb_in = li;
    @(posedge clk);
    #1;
    e.id = vec_id; e.data = ed; e.busy = eb; e.done = edn;
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (data_out !== e.data) begin
          n_miss++;
          $display("FAIL data v%0d: got %02h want %02h", e.id, data_out, e.data);
        end
        if (busy !== e.busy) begin
          n_miss++;
          $display("FAIL busy v%0d: got %b want %b", e.id, busy, e.busy);
        end
        if (done !== e.done) begin
          n_miss++;
          $display("FAIL done v%0d: got %b want %b", e.id, done, e.done);
        end
        if (msb_out !== e.data[7]) begin
          n_miss++;
          $display("FAIL msb_out v%0d: got %b want %b", e.id, msb_out, e.data[7]);
        end
        if (lsb_out !== e.data[0]) begin
          n_miss++;
          $display("FAIL lsb_out v%0d: got %b want %b", e.id, lsb_out, e.data[0]);
        end
      end
    end
  end

  logic [7:0] ror15 [15];
  initial ror15 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  initial begin : stim
    int unsigned budget;
    // reset with arbitrary inputs
    vec(1, 3'd3, 1, 4'd5, 8'hFF, 1, 1, 8'h00, 0, 0);
    vec(1, 3'd6, 1, 4'd3, 8'h5A, 0, 1, 8'h00, 0, 0);
    // single steps
    vec(0, 3'd3, 0, 4'd0, 8'hA5, 0, 0, 8'hA5, 0, 0);
    vec(0, 3'd5, 0, 4'd0, 8'h00, 0, 0, 8'h4B, 0, 0);
    vec(0, 3'd1, 0, 4'd0, 8'h00, 1, 0, 8'hA5, 0, 0);
    vec(0, 3'd2, 0, 4'd0, 8'h00, 0, 0, 8'h4A, 0, 0);
    vec(0, 3'd6, 0, 4'd0, 8'h00, 0, 0, 8'h25, 0, 0);
    vec(0, 3'd4, 0, 4'd0, 8'h00, 0, 0, 8'h92, 0, 0);
    // start on a non-burst mode executes once with no done
    vec(0, 3'd7, 1, 4'd3, 8'h00, 0, 0, 8'h00, 0, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0, 0);
    // arithmetic burst of 3
    vec(0, 3'd3, 0, 4'd0, 8'h81, 0, 0, 8'h81, 0, 0);
    vec(0, 3'd6, 1, 4'd3, 8'h00, 0, 0, 8'h81, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'hC0, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'hE0, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'hF0, 0, 1);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'hF0, 0, 0);
    // inputs ignored in RUN
    vec(0, 3'd7, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0, 0);
    vec(0, 3'd1, 1, 4'd4, 8'h00, 1, 0, 8'h00, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 1, 0, 8'h80, 1, 0);
    vec(0, 3'd3, 1, 4'd2, 8'hFF, 1, 0, 8'hC0, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 1, 0, 8'hE0, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 1, 0, 8'hF0, 0, 1);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 1, 0, 8'hF0, 0, 0);
    // zero-length burst, then a new burst accepted in the done cycle
    vec(0, 3'd3, 0, 4'd0, 8'h3C, 0, 0, 8'h3C, 0, 0);
    vec(0, 3'd4, 1, 4'd0, 8'h00, 0, 0, 8'h3C, 0, 1);
    vec(0, 3'd2, 1, 4'd2, 8'h00, 0, 1, 8'h3C, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 1, 8'h79, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 1, 8'hF3, 0, 1);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'hF3, 0, 0);
    // reset mid-burst
    vec(0, 3'd3, 0, 4'd0, 8'h0F, 0, 0, 8'h0F, 0, 0);
    vec(0, 3'd4, 1, 4'd6, 8'h00, 0, 0, 8'h0F, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'h87, 1, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'hC3, 1, 0);
    vec(1, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0, 0);
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0, 0);
    vec(0, 3'd3, 0, 4'd0, 8'h55, 0, 0, 8'h55, 0, 0);
    // maximum count wraps the rotate past WIDTH
    vec(0, 3'd3, 0, 4'd0, 8'h01, 0, 0, 8'h01, 0, 0);
    vec(0, 3'd4, 1, 4'd15, 8'h00, 0, 0, 8'h01, 1, 0);
    for (int i = 0; i < 15; i++)
      vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, ror15[i], (i < 14), (i == 14));
    vec(0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 8'h02, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
